// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg
//   Shared definitions for the UART command master and its peers:
//   FSM state encoding, default response terminator, and the cmd_parser
//   opcode set. Files using it do `import uart_cmd_pkg::*`.
package uart_cmd_pkg;

    // Command master FSM encoding. Plain constants so older blocks that
    // decode the raw state vector keep working.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_TX_WAIT = 3'd1;
    localparam logic [2:0] ST_TX_SEND = 3'd2;
    localparam logic [2:0] ST_TX_GAP  = 3'd3;
    localparam logic [2:0] ST_RX      = 3'd4;
    localparam logic [2:0] ST_FINISH  = 3'd5;

    localparam logic [7:0] DEFAULT_TERM_BYTE = 8'h01;

    // cmd_parser opcodes
    typedef enum logic [7:0] {
        CMD_TEST = 8'h04
    } cmd_opcode_e;

    // One command byte as held between acceptance and transmission
    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } cmd_byte_t;

endpackage

// File: rtl/timeout_counter.sv
// timeout_counter
//   Idle-cycle counter for the response phase. Counts enabled cycles since
//   the last clear and flags when TIMEOUT_CYCLES has been reached; it then
//   holds there until cleared.
// Ports:
//   clk      system clock
//   reset    async active-low reset
//   clear    synchronous clear (wins over enable)
//   enable   count this cycle
//   expired  count == TIMEOUT_CYCLES
module timeout_counter #(
    parameter int TIMEOUT_CYCLES = 100_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] count;

    assign expired = (count == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && !expired)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/uart_cmd_master.sv
// uart_cmd_master
//   Sends a command byte stream to a UART transmitter, then collects the
//   response from a UART receiver. The response ends on TERM_BYTE (MODE 0)
//   or after RESP_LEN bytes (MODE 1); MAX_RESP bytes without an end flags
//   overflow, and TIMEOUT_CYCLES idle cycles flag a timeout.
// Ports:
//   clk, reset                       clock, async active-low reset
//   in_valid/in_data/in_last/in_ready command byte stream in
//   tx_start/tx_data/tx_busy         async_transmitter handshake
//   rx_ready/rx_data                 async_receiver strobe + byte
//   out_valid/out_data/out_last      response byte stream (no backpressure)
//   busy, done                       transaction in progress / end pulse
//   err_timeout, err_overflow        sticky until the next command
//   resp_count                       bytes received in last transaction
module uart_cmd_master
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] TERM_BYTE      = DEFAULT_TERM_BYTE,
    parameter int         RESP_LEN       = 16,
    parameter int         MAX_RESP       = 64,
    parameter int         TIMEOUT_CYCLES = 100_000,
    parameter int         MODE           = 0,
    localparam int        CW             = $clog2(MAX_RESP + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    input  logic          tx_busy,
    input  logic          rx_ready,
    input  logic [7:0]    rx_data,
    output logic          out_valid,
    output logic [7:0]    out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic          err_timeout,
    output logic          err_overflow,
    output logic [CW-1:0] resp_count
);

    logic [2:0]    state;
    cmd_byte_t     cmd;
    logic          have_byte;   // a command byte is latched and not yet sent
    logic          expired;
    logic [CW-1:0] resp_next;
    logic          end_hit;
    logic          max_hit;

    // The latched byte is presented straight to the transmitter; it only
    // samples tx_data on tx_start.
    assign tx_data  = cmd.data;
    assign tx_start = (state == ST_TX_SEND);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_FINISH);
    assign in_ready = (state == ST_IDLE) || (state == ST_TX_WAIT && !have_byte);

    assign resp_next = resp_count + 1'b1;
    assign end_hit   = ((MODE == 0) && (rx_data == TERM_BYTE)) ||
                       ((MODE == 1) && (resp_next == CW'(RESP_LEN)));
    assign max_hit   = (resp_next == CW'(MAX_RESP));

    // Held at zero outside RX so it starts fresh on entry; a received byte
    // restarts it, and that same byte takes priority over expiry below.
    timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   ((state != ST_RX) || rx_ready),
        .enable  (state == ST_RX),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            cmd          <= '0;
            have_byte    <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_last     <= 1'b0;
            err_timeout  <= 1'b0;
            err_overflow <= 1'b0;
            resp_count   <= '0;
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        cmd          <= '{data: in_data, last: in_last};
                        have_byte    <= 1'b1;
                        err_timeout  <= 1'b0;
                        err_overflow <= 1'b0;
                        resp_count   <= '0;
                        state        <= ST_TX_WAIT;
                    end
                end
                ST_TX_WAIT: begin
                    if (!have_byte) begin
                        if (in_valid) begin
                            cmd       <= '{data: in_data, last: in_last};
                            have_byte <= 1'b1;
                        end
                    end else if (!tx_busy) begin
                        state <= ST_TX_SEND;
                    end
                end
                ST_TX_SEND: begin
                    have_byte <= 1'b0;
                    state     <= ST_TX_GAP;
                end
                // One spare cycle lets the transmitter raise tx_busy before
                // TX_WAIT looks at it again.
                ST_TX_GAP: begin
                    state <= cmd.last ? ST_RX : ST_TX_WAIT;
                end
                ST_RX: begin
                    if (rx_ready) begin
                        out_valid  <= 1'b1;
                        out_data   <= rx_data;
                        resp_count <= resp_next;
                        if (end_hit) begin
                            out_last <= 1'b1;
                            state    <= ST_FINISH;
                        end else if (max_hit) begin
                            out_last     <= 1'b1;
                            err_overflow <= 1'b1;
                            state        <= ST_FINISH;
                        end
                    end else if (expired) begin
                        err_timeout <= 1'b1;
                        state       <= ST_FINISH;
                    end
                end
                ST_FINISH: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_master.sv
// tb_uart_cmd_master
//   dut0: MODE 0, MAX_RESP 8, TIMEOUT 50.  dut1: MODE 1, RESP_LEN 4.
//   Both share stimulus; each test starts from reset. A behavioural
//   transmitter drives tx_busy from dut0's tx_start, and the responder
//   strobes rx bytes with random gaps.
module tb_uart_cmd_master;

    localparam int TMO   = 50;
    localparam int MAXR  = 8;
    localparam int RLEN1 = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0, in_last = 1'b0, rx_ready = 1'b0, tx_busy = 1'b0;
    logic [7:0] in_data = '0, rx_data = '0;

    logic       in_ready0, tx_start0, out_valid0, out_last0, busy0, done0, err_to0, err_ov0;
    logic [7:0] tx_data0, out_data0;
    logic [3:0] resp_count0;
    logic       in_ready1, tx_start1, out_valid1, out_last1, busy1, done1, err_to1, err_ov1;
    logic [7:0] tx_data1, out_data1;
    logic [3:0] resp_count1;

    uart_cmd_master #(.TERM_BYTE(8'h01), .RESP_LEN(RLEN1), .MAX_RESP(MAXR),
                      .TIMEOUT_CYCLES(TMO), .MODE(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready0), .tx_start(tx_start0), .tx_data(tx_data0), .tx_busy(tx_busy),
        .rx_ready(rx_ready), .rx_data(rx_data), .out_valid(out_valid0), .out_data(out_data0),
        .out_last(out_last0), .busy(busy0), .done(done0), .err_timeout(err_to0),
        .err_overflow(err_ov0), .resp_count(resp_count0));

    uart_cmd_master #(.TERM_BYTE(8'h01), .RESP_LEN(RLEN1), .MAX_RESP(MAXR),
                      .TIMEOUT_CYCLES(TMO), .MODE(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready1), .tx_start(tx_start1), .tx_data(tx_data1), .tx_busy(tx_busy),
        .rx_ready(rx_ready), .rx_data(rx_data), .out_valid(out_valid1), .out_data(out_data1),
        .out_last(out_last1), .busy(busy1), .done(done1), .err_timeout(err_to1),
        .err_overflow(err_ov1), .resp_count(resp_count1));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- monitor (sole writer of the capture arrays) ----------
    logic [7:0] tx_mem   [0:255];
    logic [8:0] out0_mem [0:1023];   // {last, data}
    logic [8:0] out1_mem [0:1023];
    int n_tx = 0, n_out0 = 0, n_out1 = 0, n_done0 = 0, n_done1 = 0, busy_viol = 0;

    always @(negedge clk) begin
        if (tx_start0) begin
            if (n_tx < 256) tx_mem[n_tx] = tx_data0;
            n_tx++;
            if (tx_busy) busy_viol++;
        end
        if (out_valid0) begin
            if (n_out0 < 1024) out0_mem[n_out0] = {out_last0, out_data0};
            n_out0++;
        end
        if (out_valid1) begin
            if (n_out1 < 1024) out1_mem[n_out1] = {out_last1, out_data1};
            n_out1++;
        end
        if (done0) n_done0++;
        if (done1) n_done1++;
    end

    // ---------------- transmitter model ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start0) begin
                #1 tx_busy = 1'b1;
                repeat ($urandom_range(1, 8)) @(negedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers & reference model ----------------
    logic [7:0] rx_b[$];
    int         rx_g[$];
    logic [8:0] exp_q[$];
    bit         exp_ovf;

    task automatic do_reset();
        in_valid = 1'b0; rx_ready = 1'b0;
        @(negedge clk); #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk); #2;
    endtask

    task automatic push_byte(input logic [7:0] b, input logic l);
        int n = 0;
        in_valid = 1'b1; in_data = b; in_last = l;
        while (!in_ready0 && n < 400) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        if (n >= 400) begin
            n_checks++;
            $display("FAIL push_byte: in_ready stayed 0 for %0d cycles, byte %h", n, b);
        end
    endtask

    // Returns in the cycle where tx_start for the target byte is seen.
    task automatic wait_tx(input int target);
        int n = 0;
        while (n_tx < target && n < 400) begin @(negedge clk); #2; n++; end
        if (n_tx < target) begin
            n_checks++;
            $display("FAIL wait_tx: tx_start count %0d, required %0d", n_tx, target);
        end
    endtask

    function automatic logic [7:0] nonterm_byte();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (b == 8'h01) b = 8'h02;
        return b;
    endfunction

    // n filler bytes then the terminator; first gap >=2 lands in RX.
    task automatic rand_resp(input int n, input bit with_term);
        rx_b.delete(); rx_g.delete();
        for (int i = 0; i < n; i++) begin
            rx_b.push_back(nonterm_byte());
            rx_g.push_back(i == 0 ? $urandom_range(2, 8) : $urandom_range(0, 5));
        end
        if (with_term) begin
            rx_b.push_back(8'h01);
            rx_g.push_back(n == 0 ? $urandom_range(2, 8) : $urandom_range(0, 5));
        end
    endtask

    task automatic drive_rx();
        for (int i = 0; i < rx_b.size(); i++) begin
            repeat (rx_g[i]) @(negedge clk);
            rx_ready = 1'b1; rx_data = rx_b[i];
            @(negedge clk);
            rx_ready = 1'b0;
        end
    endtask

    // Expected response: bytes pass through until the end condition for the
    // mode, or overflow at MAXR; anything after that is ignored.
    task automatic build_expect(input int mode, input int rlen);
        bit fin, ov;
        exp_q.delete(); exp_ovf = 1'b0;
        for (int i = 0; i < rx_b.size(); i++) begin
            fin = (mode == 0 && rx_b[i] == 8'h01) || (mode == 1 && i + 1 == rlen);
            ov  = !fin && (i + 1 == MAXR);
            exp_q.push_back({fin | ov, rx_b[i]});
            if (ov) exp_ovf = 1'b1;
            if (fin | ov) break;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_checks++; if ({busy0, done0, tx_start0, out_valid0, out_last0} !== 5'b0)
            $display("FAIL reset_ctrl: got %b required 00000", {busy0, done0, tx_start0, out_valid0, out_last0});
        else n_pass++;
        n_checks++; if ({err_to0, err_ov0, resp_count0} !== 6'b0)
            $display("FAIL reset_err: got %b required 000000", {err_to0, err_ov0, resp_count0});
        else n_pass++;
        n_checks++; if ({tx_data0, out_data0} !== 16'h0)
            $display("FAIL reset_data: got %h required 0000", {tx_data0, out_data0});
        else n_pass++;
        n_checks++; if (in_ready0 !== 1'b1)
            $display("FAIL reset_in_ready: got %b required 1", in_ready0);
        else n_pass++;
    endtask

    task automatic test_single_cmd();
        int bt, bo, bd;
        do_reset();
        bt = n_tx; bo = n_out0; bd = n_done0;
        rand_resp($urandom_range(2, 5), 1'b1);
        build_expect(0, RLEN1);
        push_byte(8'h04, 1'b1);
        wait_tx(bt + 1);
        drive_rx();
        repeat (60) @(negedge clk);
        n_checks++; if (n_tx - bt !== 1 || tx_mem[bt] !== 8'h04)
            $display("FAIL single_tx: count %0d byte %h, required 1 byte 04", n_tx - bt, tx_mem[bt]);
        else n_pass++;
        n_checks++; if (n_out0 - bo !== exp_q.size())
            $display("FAIL single_out_count: got %0d required %0d", n_out0 - bo, exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++; if (out0_mem[bo + i] !== exp_q[i])
                $display("FAIL single_out[%0d]: got %h required %h", i, out0_mem[bo + i], exp_q[i]);
            else n_pass++;
        end
        n_checks++; if (n_done0 - bd !== 1 || {err_to0, err_ov0} !== 2'b00)
            $display("FAIL single_end: done %0d err %b, required 1 / 00", n_done0 - bd, {err_to0, err_ov0});
        else n_pass++;
        n_checks++; if (resp_count0 !== 4'(exp_q.size()))
            $display("FAIL single_resp_count: got %0d required %0d", resp_count0, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_multi_cmd();
        logic [7:0] cmdv [3];
        int bt, bv;
        cmdv[0] = 8'hA5; cmdv[1] = 8'h5A; cmdv[2] = 8'h0F;
        do_reset();
        bt = n_tx; bv = busy_viol;
        for (int i = 0; i < 3; i++) push_byte(cmdv[i], i == 2);
        wait_tx(bt + 3);
        rx_b.delete(); rx_g.delete(); rx_b.push_back(8'h01); rx_g.push_back(3);
        drive_rx();
        repeat (10) @(negedge clk);
        n_checks++; if (n_tx - bt !== 3)
            $display("FAIL multi_tx_count: got %0d required 3", n_tx - bt);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (tx_mem[bt + i] !== cmdv[i])
                $display("FAIL multi_tx[%0d]: got %h required %h", i, tx_mem[bt + i], cmdv[i]);
            else n_pass++;
        end
        n_checks++; if (busy_viol - bv !== 0)
            $display("FAIL multi_tx_busy: %0d starts while busy, required 0", busy_viol - bv);
        else n_pass++;
        n_checks++; if (busy0 !== 1'b0 || resp_count0 !== 4'd1)
            $display("FAIL multi_end: busy %b resp_count %0d, required 0 / 1", busy0, resp_count0);
        else n_pass++;
    endtask

    task automatic test_random_cmds();
        logic [7:0] cmdv[$];
        int bt, bo, bd, len;
        do_reset();
        for (int it = 0; it < 6; it++) begin
            cmdv.delete();
            len = $urandom_range(1, 4);
            for (int i = 0; i < len; i++) cmdv.push_back(8'($urandom_range(0, 255)));
            bt = n_tx; bo = n_out0; bd = n_done0;
            rand_resp($urandom_range(0, 5), 1'b1);
            build_expect(0, RLEN1);
            for (int i = 0; i < len; i++) push_byte(cmdv[i], i == len - 1);
            wait_tx(bt + len);
            drive_rx();
            repeat (8) @(negedge clk);
            n_checks++; if (n_tx - bt !== len)
                $display("FAIL rand%0d_tx_count: got %0d required %0d", it, n_tx - bt, len);
            else n_pass++;
            for (int i = 0; i < len; i++) begin
                n_checks++; if (tx_mem[bt + i] !== cmdv[i])
                    $display("FAIL rand%0d_tx[%0d]: got %h required %h", it, i, tx_mem[bt + i], cmdv[i]);
                else n_pass++;
            end
            n_checks++; if (n_out0 - bo !== exp_q.size())
                $display("FAIL rand%0d_out_count: got %0d required %0d", it, n_out0 - bo, exp_q.size());
            else n_pass++;
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++; if (out0_mem[bo + i] !== exp_q[i])
                    $display("FAIL rand%0d_out[%0d]: got %h required %h", it, i, out0_mem[bo + i], exp_q[i]);
                else n_pass++;
            end
            n_checks++; if (n_done0 - bd !== 1 || resp_count0 !== 4'(exp_q.size()) || {err_to0, err_ov0} !== 2'b00)
                $display("FAIL rand%0d_end: done %0d resp_count %0d err %b, required 1 / %0d / 00",
                         it, n_done0 - bd, resp_count0, {err_to0, err_ov0}, exp_q.size());
            else n_pass++;
        end
    endtask

    task automatic test_mode1_len();
        int bt, bo, bd;
        do_reset();
        bt = n_tx; bo = n_out1; bd = n_done1;
        rand_resp(6, 1'b0);
        build_expect(1, RLEN1);
        push_byte(8'h04, 1'b1);
        wait_tx(bt + 1);
        drive_rx();
        repeat (10) @(negedge clk);
        n_checks++; if (n_out1 - bo !== 4)
            $display("FAIL mode1_out_count: got %0d required 4", n_out1 - bo);
        else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++; if (out1_mem[bo + i] !== exp_q[i])
                $display("FAIL mode1_out[%0d]: got %h required %h", i, out1_mem[bo + i], exp_q[i]);
            else n_pass++;
        end
        n_checks++; if (resp_count1 !== 4'd4 || n_done1 - bd !== 1 || {err_to1, err_ov1} !== 2'b00)
            $display("FAIL mode1_end: resp_count %0d done %0d err %b, required 4 / 1 / 00",
                     resp_count1, n_done1 - bd, {err_to1, err_ov1});
        else n_pass++;
    endtask

    task automatic test_overflow();
        int bt, bo, bd;
        do_reset();
        bt = n_tx; bo = n_out0; bd = n_done0;
        rand_resp(10, 1'b0);
        build_expect(0, RLEN1);
        push_byte(8'h04, 1'b1);
        wait_tx(bt + 1);
        drive_rx();
        repeat (10) @(negedge clk);
        n_checks++; if (n_out0 - bo !== MAXR)
            $display("FAIL ovf_out_count: got %0d required %0d", n_out0 - bo, MAXR);
        else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++; if (out0_mem[bo + i] !== exp_q[i])
                $display("FAIL ovf_out[%0d]: got %h required %h", i, out0_mem[bo + i], exp_q[i]);
            else n_pass++;
        end
        n_checks++; if (err_ov0 !== exp_ovf || err_to0 !== 1'b0)
            $display("FAIL ovf_flags: ovf %b to %b, required %b / 0", err_ov0, err_to0, exp_ovf);
        else n_pass++;
        n_checks++; if (resp_count0 !== 4'(MAXR) || n_done0 - bd !== 1)
            $display("FAIL ovf_end: resp_count %0d done %0d, required %0d / 1", resp_count0, n_done0 - bd, MAXR);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int bt, bo;
        do_reset();
        bt = n_tx; bo = n_out0;
        push_byte(8'h04, 1'b1);
        wait_tx(bt + 1);
        // RX index 50 is 52 negedges after the TX_SEND cycle
        repeat (52) @(negedge clk);
        n_checks++; if (err_to0 !== 1'b0 || done0 !== 1'b0)
            $display("FAIL tmo_early: err_timeout %b done %b, required 0 / 0", err_to0, done0);
        else n_pass++;
        @(negedge clk);
        n_checks++; if (err_to0 !== 1'b1 || done0 !== 1'b1)
            $display("FAIL tmo_fire: err_timeout %b done %b, required 1 / 1", err_to0, done0);
        else n_pass++;
        n_checks++; if (resp_count0 !== 4'd0 || n_out0 - bo !== 0 || err_ov0 !== 1'b0)
            $display("FAIL tmo_no_data: resp_count %0d outs %0d ovf %b, required 0 / 0 / 0",
                     resp_count0, n_out0 - bo, err_ov0);
        else n_pass++;
        @(negedge clk);
        n_checks++; if (done0 !== 1'b0 || busy0 !== 1'b0 || err_to0 !== 1'b1)
            $display("FAIL tmo_after: done %b busy %b err_timeout %b, required 0 / 0 / 1", done0, busy0, err_to0);
        else n_pass++;
    endtask

    task automatic test_timeout_race();
        int bt, bd;
        do_reset();
        bt = n_tx; bd = n_done0;
        push_byte(8'h04, 1'b1);
        wait_tx(bt + 1);
        repeat (52) @(negedge clk);
        rx_ready = 1'b1; rx_data = 8'h33;
        @(negedge clk);
        rx_ready = 1'b0;
        n_checks++; if (out_valid0 !== 1'b1 || out_data0 !== 8'h33 || out_last0 !== 1'b0)
            $display("FAIL race_byte: valid %b data %h last %b, required 1 / 33 / 0", out_valid0, out_data0, out_last0);
        else n_pass++;
        n_checks++; if (err_to0 !== 1'b0 || busy0 !== 1'b1)
            $display("FAIL race_no_tmo: err_timeout %b busy %b, required 0 / 1", err_to0, busy0);
        else n_pass++;
        repeat (5) @(negedge clk);
        rx_ready = 1'b1; rx_data = 8'h01;
        @(negedge clk);
        rx_ready = 1'b0;
        n_checks++; if (out_valid0 !== 1'b1 || out_last0 !== 1'b1 || done0 !== 1'b1)
            $display("FAIL race_term: valid %b last %b done %b, required 1 / 1 / 1", out_valid0, out_last0, done0);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if (resp_count0 !== 4'd2 || err_to0 !== 1'b0 || n_done0 - bd !== 1)
            $display("FAIL race_end: resp_count %0d err_timeout %b done %0d, required 2 / 0 / 1",
                     resp_count0, err_to0, n_done0 - bd);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int bt, bo, bd;
        do_reset();
        bt = n_tx; bd = n_done0;
        push_byte(8'h11, 1'b0);
        wait_tx(bt + 1);
        repeat (2) @(negedge clk);   // TX_WAIT for the 2nd byte
        #2;
        n_checks++; if (busy0 !== 1'b1 || tx_data0 !== 8'h11)
            $display("FAIL rstmid_pre: busy %b tx_data %h, required 1 / 11", busy0, tx_data0);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++; if ({busy0, tx_start0, out_valid0, out_last0, done0, err_to0, err_ov0} !== 7'b0 ||
                        {tx_data0, out_data0, resp_count0} !== 20'h0)
            $display("FAIL rstmid_outputs: ctrl %b data %h, required 0 / 0",
                     {busy0, tx_start0, out_valid0, out_last0, done0, err_to0, err_ov0},
                     {tx_data0, out_data0, resp_count0});
        else n_pass++;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk); #2;
        n_checks++; if (n_done0 - bd !== 0)
            $display("FAIL rstmid_no_done: got %0d done pulses required 0", n_done0 - bd);
        else n_pass++;
        bt = n_tx; bo = n_out0; bd = n_done0;
        rand_resp($urandom_range(1, 4), 1'b1);
        build_expect(0, RLEN1);
        push_byte(8'h04, 1'b1);
        wait_tx(bt + 1);
        drive_rx();
        repeat (8) @(negedge clk);
        n_checks++; if (n_out0 - bo !== exp_q.size() || out0_mem[bo + exp_q.size() - 1] !== exp_q[exp_q.size() - 1])
            $display("FAIL rstmid_next: outs %0d last %h, required %0d / %h", n_out0 - bo,
                     out0_mem[bo + exp_q.size() - 1], exp_q.size(), exp_q[exp_q.size() - 1]);
        else n_pass++;
        n_checks++; if (n_done0 - bd !== 1 || tx_mem[bt] !== 8'h04)
            $display("FAIL rstmid_next_end: done %0d tx %h, required 1 / 04", n_done0 - bd, tx_mem[bt]);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_cmd();
        test_multi_cmd();
        test_random_cmds();
        test_mode1_len();
        test_overflow();
        test_timeout();
        test_timeout_race();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_cmd_master.md
UART_CMD_MASTER -- requirements
Module: uart_cmd_master

Interface
REQ-001 SHALL have parameter TERM_BYTE, default 8'h01: response terminator byte in MODE 0.
REQ-002 SHALL have parameter RESP_LEN, default 16: fixed response byte count in MODE 1 (1..MAX_RESP).
REQ-003 SHALL have parameter MAX_RESP, default 64: response byte limit before overflow error.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 100_000: maximum idle clk cycles between response bytes.
REQ-005 SHALL have parameter MODE, default 0: 0 ends the response on the terminator byte, 1 ends it after a fixed count.
REQ-006 Ports SHALL be as follows (one clock, clk; reset is asynchronous, active-low):
 clk  in  1  system clock
 reset  in  1  async active-low reset
 in_valid  in  1  command byte valid
 in_data  in  8  command byte
 in_last  in  1  final command byte
 in_ready  out  1  command byte accepted
 tx_start  out  1  one-cycle pulse to async_transmitter
 tx_data  out  8  byte to transmit
 tx_busy  in  1  transmitter busy
 rx_ready  in  1  one-cycle received-byte strobe from async_receiver
 rx_data  in  8  received byte
 out_valid  out  1  one-cycle response byte strobe (no backpressure)
 out_data  out  8  response byte
 out_last  out  1  with out_valid, final response byte
 busy  out  1  transaction in progress
 done  out  1  one-cycle pulse at transaction end
 err_timeout  out  1  sticky until next command
 err_overflow  out  1  sticky until next command
 resp_count  out  $clog2(MAX_RESP+1)  bytes received in the last transaction

Function
REQ-007 States SHALL be IDLE, TX_WAIT, TX_SEND, TX_GAP, RX, FINISH.
REQ-008 IDLE SHALL drive in_ready=1. When in_valid=1, it SHALL latch in_data and in_last, clear both err flags and resp_count, and go to TX_WAIT.
REQ-009 TX_WAIT SHALL hold until tx_busy=0, then go to TX_SEND.
REQ-010 TX_SEND SHALL assert tx_start=1 for exactly one cycle, with tx_data equal to the latched byte, then go to TX_GAP.
REQ-011 TX_GAP SHALL last one cycle. If the latched last=1 it SHALL go to RX; otherwise it SHALL go to TX_WAIT with in_ready=1 in TX_WAIT to fetch the next byte.
REQ-012 In TX_WAIT, the next command byte SHALL be accepted only on in_valid&in_ready. in_ready SHALL drop after acceptance. A byte SHALL be sent only once one has been accepted.
REQ-013 In RX, each rx_ready SHALL produce out_valid=1 and out_data=rx_data on the next cycle (1-cycle latency), increment resp_count, and reset the timeout counter.
REQ-014 MODE 0: when the received byte equals TERM_BYTE, that byte SHALL be emitted with out_last=1 and the block SHALL go to FINISH.
REQ-015 MODE 1: when resp_count reaches RESP_LEN, that byte SHALL be emitted with out_last=1 and the block SHALL go to FINISH.
REQ-016 When resp_count reaches MAX_RESP without completion, the block SHALL set err_overflow, emit that byte with out_last=1, and go to FINISH.
REQ-017 When the timeout counter reaches TIMEOUT_CYCLES in RX, the block SHALL set err_timeout, emit no byte, and go to FINISH. The counter SHALL start at RX entry.
REQ-018 If rx_ready coincides with the timeout expiring, the byte SHALL win and the counter SHALL reset.
REQ-019 FINISH SHALL pulse done=1 for one cycle and then go to IDLE.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 rx_ready outside RX SHALL be ignored.
REQ-022 in_valid outside the accepting states SHALL be ignored.

Reset
REQ-023 reset=0 SHALL immediately force state IDLE and drive tx_start, out_valid, out_last, done, busy, err_*, resp_count, out_data and tx_data to 0, and the counters to 0.
REQ-024 Reset mid-transaction SHALL abandon it without a done pulse. A transmit already started in the transmitter SHALL not be cancelled.

Structure
REQ-025 State encoding and the default TERM_BYTE SHALL reside in shared package uart_cmd_pkg, alongside the cmd_parser opcodes (test cmd 8'h04).
REQ-026 The timeout counter SHALL be the sub-module timeout_counter (clear, enable, expired), of width $clog2(TIMEOUT_CYCLES+1).

Verification
REQ-027 Loopback bench (async_transmitter/async_receiver, 100 MHz, 12 Mbaud, top_md5): single byte 8'h04 with in_last=1 -> response bytes streamed, last byte 8'h01 with out_last=1, one done pulse, no err.
REQ-028 Three-byte command A5,5A,0F -> tx_start pulses exactly 3 times, each while tx_busy=0, bytes in order.
REQ-029 MODE=1, RESP_LEN=4, responder sends 6 bytes -> exactly 4 out_valid, 4th with out_last, resp_count=4, extra bytes ignored.
REQ-030 MODE=0, MAX_RESP=8, responder never sends 8'h01 -> 8 bytes, err_overflow=1, done pulse.
REQ-031 TIMEOUT_CYCLES=50, no response -> err_timeout=1 at cycle 50 after RX entry, resp_count=0. Rerun with rx_ready on cycle 50 -> byte accepted, no timeout.
REQ-032 reset=0 pulse during TX_WAIT of the 2nd byte -> all outputs 0 immediately, no done. The next command completes normally.
